spi_frame_sequencer: RTL

- Sits between two measurement sources and the byte-wide SPI transmitter (spi_send / spi_data_out / spi_send_done / busy handshake).
- Arbitrates between the frequency-result and period-result requesters round-robin and latches the winner's 32-bit value.
- Sends the value as one frame: header byte, DATA_BYTES payload bytes MSB-first, optional checksum byte.
- Drives every per-byte handshake of the transmitter, which runs on its slow divided clock, and reports per-requester completion and timeout.

---
 rtl/spi_seq_pkg.sv | 23 ++
 rtl/spi_seq_arbiter.sv | 40 ++++
 rtl/spi_frame_sequencer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI frame sequencer.
// Optional checksum byte is controlled by the SPI_SEQ_CHECKSUM_EN macro.
package spi_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEND = 3'd2,
    ACK  = 3'd3,
    GAP  = 3'd4,
    FIN  = 3'd5
  } seq_state_e;

  localparam logic       CH_FREQ        = 1'b0;
  localparam logic       CH_PERIOD      = 1'b1;
  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  // One step of the mod-256 frame checksum
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] data);
    return acc + data;
  endfunction

endpackage

// File: rtl/spi_seq_arbiter.sv
// Two-way round-robin arbiter: combinational grant, registered preference
// pointer that moves away from the channel just served on each completed frame.
module spi_seq_arbiter
  import spi_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       fin_s,
  input  logic       served_ch,
  output logic       gnt_valid_s,
  output logic       gnt_ch_s
);

  logic ptr_r;

  // Grant: a lone requester wins outright, contention is settled by the pointer
  always_comb begin
    gnt_valid_s = |req;
    gnt_ch_s    = CH_FREQ;
    case (req)
      2'b01:   gnt_ch_s = CH_FREQ;
      2'b10:   gnt_ch_s = CH_PERIOD;
      2'b11:   gnt_ch_s = ptr_r;
      default: gnt_ch_s = CH_FREQ;
    endcase
  end

  // Pointer: after a completed frame, prefer the channel that was not served
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r <= CH_FREQ;
    end else if (fin_s) begin
      ptr_r <= ~served_ch;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/spi_frame_sequencer.sv
// Frame sequencer in front of a byte-wide SPI transmitter. Arbitrates the
// frequency/period requesters, then sends header, payload MSB-first and,
// when SPI_SEQ_CHECKSUM_EN is defined, a mod-256 checksum byte.
module spi_frame_sequencer
  import spi_seq_pkg::*;
#(
  parameter int         DATA_BYTES     = 4,
  parameter logic [7:0] HEADER         = DEFAULT_HEADER,
  parameter int         GAP_CYCLES     = 16,
  parameter int         TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [31:0] value0,
  input  logic [31:0] value1,
  output logic [1:0]  ack,
  output logic        err_timeout,
  output logic        spi_send,
  output logic [7:0]  spi_data_out,
  output logic        busy,
  input  logic        spi_send_done,
  output logic        frame_active
);

`ifdef SPI_SEQ_CHECKSUM_EN
  localparam int CSUM_BYTES = 1;
`else
  localparam int CSUM_BYTES = 0;
`endif
  localparam logic [2:0]    PAYLOAD_LAST = 3'(DATA_BYTES);
  localparam logic [2:0]    LAST_IDX     = 3'(DATA_BYTES + CSUM_BYTES);
  localparam int            TW           = $clog2(TIMEOUT_CYCLES + 1);
  localparam int            GW           = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST     = GW'(GAP_CYCLES - 1);

  seq_state_e    state_r, state_nxt_s;
  logic          ch_r, ch_nxt_s;
  logic [31:0]   value_r, value_nxt_s;
  logic [2:0]    idx_r, idx_nxt_s;
  logic [GW-1:0] gap_cnt_r, gap_nxt_s;
  logic [TW-1:0] tmo_cnt_r, tmo_nxt_s;
  logic          send_r, send_nxt_s;
  logic          busy_r, busy_nxt_s;
  logic [7:0]    data_r, data_nxt_s;
  logic [1:0]    ack_r, ack_nxt_s;
  logic          err_r, err_nxt_s;
  logic          active_r, active_nxt_s;
  logic          done_ff1_r, done_ff2_r, done_s;
  logic          gnt_valid_s, gnt_ch_s, fin_s;
  logic [2:0]    shift_s;
  logic [7:0]    byte_s;
`ifdef SPI_SEQ_CHECKSUM_EN
  logic [7:0]    sum_r, sum_nxt_s;
`endif

  spi_seq_arbiter u_arbiter (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .fin_s       (fin_s),
    .served_ch   (ch_r),
    .gnt_valid_s (gnt_valid_s),
    .gnt_ch_s    (gnt_ch_s)
  );

  // Bring the transmitter's done flag into the clk domain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_ff1_r <= 1'b0;
      done_ff2_r <= 1'b0;
    end else begin
      done_ff1_r <= spi_send_done;
      done_ff2_r <= done_ff1_r;
    end
  end
  assign done_s = done_ff2_r;

  // Byte for the current index: header, payload MSB-first, then checksum
  always_comb begin
    shift_s = PAYLOAD_LAST - idx_r;
    if (idx_r == 3'd0) begin
      byte_s = HEADER ^ {7'd0, ch_r};
    end else if (idx_r <= PAYLOAD_LAST) begin
      byte_s = 8'(value_r >> {shift_s, 3'b000});
    end else begin
`ifdef SPI_SEQ_CHECKSUM_EN
      byte_s = sum_r;
`else
      byte_s = HEADER ^ {7'd0, ch_r};
`endif
    end
  end

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_nxt_s  = state_r;
    ch_nxt_s     = ch_r;
    value_nxt_s  = value_r;
    idx_nxt_s    = idx_r;
    gap_nxt_s    = gap_cnt_r;
    tmo_nxt_s    = tmo_cnt_r;
    send_nxt_s   = send_r;
    busy_nxt_s   = busy_r;
    data_nxt_s   = data_r;
    ack_nxt_s    = 2'b00;
    err_nxt_s    = err_r;
    active_nxt_s = active_r;
    fin_s        = 1'b0;
`ifdef SPI_SEQ_CHECKSUM_EN
    sum_nxt_s    = sum_r;
`endif
    case (state_r)
      IDLE: begin
        send_nxt_s = 1'b0;
        busy_nxt_s = 1'b0;
        if (gnt_valid_s) begin
          ch_nxt_s     = gnt_ch_s;
          value_nxt_s  = (gnt_ch_s == CH_PERIOD) ? value1 : value0;
          idx_nxt_s    = 3'd0;
          active_nxt_s = 1'b1;
`ifdef SPI_SEQ_CHECKSUM_EN
          sum_nxt_s    = 8'd0;
`endif
          state_nxt_s  = LOAD;
        end else begin
          state_nxt_s  = IDLE;
        end
      end
      LOAD: begin
        data_nxt_s  = byte_s;
        send_nxt_s  = 1'b1;
        tmo_nxt_s   = '0;
`ifdef SPI_SEQ_CHECKSUM_EN
        if (idx_r != LAST_IDX) begin
          sum_nxt_s = csum_add(sum_r, byte_s);
        end else begin
          sum_nxt_s = sum_r;
        end
`endif
        state_nxt_s = SEND;
      end
      SEND: begin
        if (done_s) begin
          send_nxt_s  = 1'b0;
          busy_nxt_s  = 1'b1;
          tmo_nxt_s   = '0;
          state_nxt_s = ACK;
        end else if (tmo_cnt_r == TMO_LAST) begin
          send_nxt_s       = 1'b0;
          busy_nxt_s       = 1'b0;
          err_nxt_s        = 1'b1;
          ack_nxt_s[ch_r]  = 1'b1;
          active_nxt_s     = 1'b0;
          tmo_nxt_s        = '0;
          state_nxt_s      = IDLE;
        end else begin
          tmo_nxt_s = tmo_cnt_r + 1'b1;
        end
      end
      ACK: begin
        if (!done_s) begin
          busy_nxt_s = 1'b0;
          gap_nxt_s  = '0;
          tmo_nxt_s  = '0;
          if (idx_r == LAST_IDX) begin
            state_nxt_s = FIN;
          end else begin
            state_nxt_s = GAP;
          end
        end else if (tmo_cnt_r == TMO_LAST) begin
          send_nxt_s       = 1'b0;
          busy_nxt_s       = 1'b0;
          err_nxt_s        = 1'b1;
          ack_nxt_s[ch_r]  = 1'b1;
          active_nxt_s     = 1'b0;
          tmo_nxt_s        = '0;
          state_nxt_s      = IDLE;
        end else begin
          tmo_nxt_s = tmo_cnt_r + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          gap_nxt_s   = '0;
          idx_nxt_s   = idx_r + 3'd1;
          state_nxt_s = LOAD;
        end else begin
          gap_nxt_s   = gap_cnt_r + 1'b1;
        end
      end
      FIN: begin
        ack_nxt_s[ch_r] = 1'b1;
        err_nxt_s       = 1'b0;
        active_nxt_s    = 1'b0;
        fin_s           = 1'b1;
        state_nxt_s     = IDLE;
      end
      default: begin
        send_nxt_s   = 1'b0;
        busy_nxt_s   = 1'b0;
        active_nxt_s = 1'b0;
        state_nxt_s  = IDLE;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      ch_r      <= CH_FREQ;
      value_r   <= 32'd0;
      idx_r     <= 3'd0;
      gap_cnt_r <= '0;
      tmo_cnt_r <= '0;
      send_r    <= 1'b0;
      busy_r    <= 1'b0;
      data_r    <= 8'd0;
      ack_r     <= 2'b00;
      err_r     <= 1'b0;
      active_r  <= 1'b0;
`ifdef SPI_SEQ_CHECKSUM_EN
      sum_r     <= 8'd0;
`endif
    end else begin
      state_r   <= state_nxt_s;
      ch_r      <= ch_nxt_s;
      value_r   <= value_nxt_s;
      idx_r     <= idx_nxt_s;
      gap_cnt_r <= gap_nxt_s;
      tmo_cnt_r <= tmo_nxt_s;
      send_r    <= send_nxt_s;
      busy_r    <= busy_nxt_s;
      data_r    <= data_nxt_s;
      ack_r     <= ack_nxt_s;
      err_r     <= err_nxt_s;
      active_r  <= active_nxt_s;
`ifdef SPI_SEQ_CHECKSUM_EN
      sum_r     <= sum_nxt_s;
`endif
    end
  end

  assign spi_send     = send_r;
  assign busy         = busy_r;
  assign spi_data_out = data_r;
  assign ack          = ack_r;
  assign err_timeout  = err_r;
  assign frame_active = active_r;

endmodule
